// File: rtl/instr_fetch_sequencer_if.sv
// Instruction memory fetch bus: request/valid handshake between the
// fetch sequencer (master) and instruction memory (slave).
interface instr_fetch_sequencer_if #(
   parameter int PC_W    = 16,
   parameter int INSTR_W = 32
);
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_valid;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_valid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_valid,
      output imem_rdata
   );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch and sequencing for the 16-bit MIPS core.
// Fetches one word, presents it to the control unit until the datapath
// releases it, then resolves the next PC from the jump/branch decision.
module instr_fetch_sequencer #(
   parameter int              PC_W     = 16,
   parameter int              INSTR_W  = 32,
   parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
   parameter logic [5:0]      HALT_OP  = 6'b111111
) (
   input  logic                    clk,
   input  logic                    rst_n,
   instr_fetch_sequencer_if.master imemBus,
   input  logic                    stall,
   input  logic                    beq,
   input  logic                    jump,
   input  logic                    zero,
   output logic [INSTR_W-1:0]      instr,
   output logic [5:0]              opcode,
   output logic                    instr_valid,
   output logic [PC_W-1:0]         pc_plus1,
   output logic [15:0]             retired,
   output logic                    halted
);

   // The single beq control line serves both beq and bne; bne inverts zero.
   localparam logic [5:0] BNE_OP = 6'b000101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t          state;
   state_t          nextState;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] nextPc;
   logic [PC_W-1:0] pcInc;
   logic            loadInstr;
   logic            retire;

   // Jump beats a taken branch; the branch add wraps with the carry dropped.
   function automatic logic [PC_W-1:0] resolveNextPc(
      input logic [PC_W-1:0] linkPc,
      input logic [15:0]     imm,
      input logic [5:0]      op,
      input logic            isJump,
      input logic            isBeq,
      input logic            isZero
   );
      logic [PC_W-1:0] offset;
      offset = PC_W'(imm);
      if (isJump) begin
         return offset;
      end
      if (isBeq && (isZero ^ (op == BNE_OP))) begin
         return linkPc + offset;
      end
      return linkPc;
   endfunction

   assign pcInc             = pc + PC_W'(1);
   assign pc_plus1          = pcInc;
   assign opcode            = instr[31:26];
   assign imemBus.imem_addr = pc;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and sequencing control; the visible outputs decode from state only.
   always_comb begin
      nextState        = state;
      nextPc           = pc;
      loadInstr        = 1'b0;
      retire           = 1'b0;
      imemBus.imem_req = 1'b0;
      instr_valid      = 1'b0;
      halted           = 1'b0;
      case (state)
         IDLE: begin
            nextState = FETCH;
         end
         FETCH: begin
            imemBus.imem_req = 1'b1;
            if (imemBus.imem_valid) begin
               loadInstr = 1'b1;
               nextState = ISSUE;
            end
         end
         ISSUE: begin
            instr_valid = 1'b1;
            if (!stall) begin
               retire = 1'b1;
               if (opcode == HALT_OP) begin
                  nextState = HALT;
               end else begin
                  nextPc    = resolveNextPc(pcInc, instr[15:0], opcode, jump, beq, zero);
                  nextState = FETCH;
               end
            end
         end
         HALT: begin
            halted = 1'b1;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // PC, instruction register and retirement counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= RESET_PC;
         instr   <= '0;
         retired <= '0;
      end else begin
         pc <= nextPc;
         if (loadInstr) begin
            instr <= imemBus.imem_rdata;
         end
         if (retire) begin
            retired <= retired + 16'd1;
         end
      end
   end

endmodule

// File: doc/instr_fetch_sequencer.md
# instr_fetch_sequencer

Instruction fetch and sequencing block for the 16-bit MIPS core; it is the producer side of the opcode interface that the control unit decodes.
- Fetches 32-bit instruction words from instruction memory over a request/valid handshake.
- Presents the opcode and full instruction for one or more issue cycles.
- Samples the control unit's `beq`/`jump` outputs and the ALU `zero` flag to compute the next PC.
- Supplies the link address for `jal`.

## Interface
- `PC_W`, 16, program counter width; the PC is a word address.
- `INSTR_W`, 32, instruction width; the opcode is bits [31:26].
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `HALT_OP`, 6'b111111, opcode that halts the sequencer.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  PC_W  fetch word address; equals PC.
- `imem_valid`  in  1  read data valid.
- `imem_rdata`  in  INSTR_W  instruction word.
- `stall`  in  1  datapath hold; extends the issue cycle.
- `beq`  in  1  branch instruction, from the control unit.
- `jump`  in  1  jump/jal, from the control unit.
- `zero`  in  1  ALU zero flag.
- `instr`  out  INSTR_W  instruction register.
- `opcode`  out  6  `instr[31:26]`, driven to the control unit.
- `instr_valid`  out  1  instruction is issuing.
- `pc_plus1`  out  PC_W  PC+1 modulo 2^PC_W; this is the jal link value.
- `retired`  out  16  count of completed instructions, wraps at 16'hFFFF to 0.
- `halted`  out  1  HALT state reached.

## Operation
- States: IDLE, FETCH, ISSUE, HALT.
- Reset (async, while `rst_n`=0):
  - state=IDLE, PC=RESET_PC, `instr`=0, `retired`=0.
  - `imem_req`=0, `instr_valid`=0, `halted`=0.
  - `opcode`=0, `pc_plus1`=RESET_PC+1.
- IDLE: unconditionally goes to FETCH on the next edge.
- FETCH:
  - `imem_req`=1 and `imem_addr`=PC, held stable until valid.
  - On `imem_valid`=1: `instr`<=`imem_rdata` and the state goes to ISSUE.
  - Otherwise the state stays in FETCH; there is no timeout.
- ISSUE:
  - `instr_valid`=1 and `imem_req`=0.
  - If `stall`=1: stay in ISSUE; PC and `instr` hold.
  - Else if `opcode`==HALT_OP: go to HALT. PC holds and `retired` increments.
  - Else: compute the next PC, increment `retired`, go to FETCH.
- Next-PC priority, evaluated in the final (non-stalled) ISSUE cycle:
  1. `jump`=1: PC <= `instr[15:0]`.
  2. Branch taken: PC <= `pc_plus1` + `instr[15:0]`. The 16-bit add wraps and the carry is discarded. Branch taken = `beq` & (`zero` XOR (`opcode`==6'b000101)), so one `beq` input covers both beq and bne.
  3. Otherwise: PC <= `pc_plus1`.
- The combinational inputs `beq`, `jump` and `zero` are sampled only in the final ISSUE cycle and ignored in all other states.
- HALT: `halted`=1, `imem_req`=0, `instr_valid`=0. Only reset exits HALT.
- `imem_valid` outside FETCH is ignored and must not change `instr`.
- `jump` and taken branch asserted together: `jump` wins.

## Timing
- `imem_req`, `imem_addr`, `instr_valid` and `halted` decode from registered state and PC only, with no input-to-output combinational path.
- `opcode` is a slice of the register.
- Zero-wait memory gives 2 cycles per instruction:
  - Cycle N: FETCH, with `imem_valid`=1.
  - Cycle N+1: ISSUE.
  - Cycle N+2: FETCH at the new PC.
- Each wait cycle with `imem_valid`=0 adds one cycle.
- Each stall cycle adds one cycle.
- The first request is at the second edge after `rst_n` rises.
- `retired` updates on the same edge that leaves ISSUE.
- Reset asserted mid-FETCH or mid-ISSUE takes effect immediately (async). No partial update survives.

## Test plan
- Reset release, memory returns 0x00000000 at addresses 0,1,2 with zero wait: `imem_addr` sequences 0,1,2; `instr_valid` pulses every second cycle; `retired`=3 after the third issue.
- beq with `zero`=1 at PC=5 and `instr[15:0]`=16'hFFFC: next `imem_addr`=16'h0002. Same instruction with `zero`=0: next address is 6. bne (opcode 000101) with `zero`=0: redirects.
- jal at PC=16'h0010 with `instr[15:0]`=16'h0100 and `jump`=1: `pc_plus1`=16'h0011 during issue; next `imem_addr`=16'h0100. `jump`=1 with a taken branch: the jump target is used.
- 3 cycles of `imem_valid`=0, then `stall`=1 for 2 ISSUE cycles: address is held; `instr_valid` is high for 3 cycles; `retired` increments once.
- Opcode 111111 fetched: `halted`=1 and `imem_req` stays 0 for 20 cycles. Then `rst_n` pulse: PC=RESET_PC, `retired`=0, fetch resumes.
- `rst_n` low mid-ISSUE with stall: all outputs immediately reach reset values. `retired` wrap: preload 16'hFFFF, then one retire gives 0.
